// File: rtl/tmem_pkg.sv
// rtl/tmem_pkg.sv - shared defaults and derived-width helpers for the ping-pong activation buffer
package tmem_pkg;

    // Defaults reproduce the layer-1 geometry: 128 x 4-bit in, 4 x 128-bit out.
    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_RD_W   = 128;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Entries packed into one read word.
    function automatic int calc_k(input int data_w, input int rd_w);
        return rd_w / data_w;
    endfunction

    // Read words per bank.
    function automatic int calc_rd_depth(input int data_w, input int depth, input int rd_w);
        return depth / calc_k(data_w, rd_w);
    endfunction

    // Write address width; producer and buffer must agree on it.
    function automatic int calc_wa_w(input int depth);
        return clog2(depth);
    endfunction

    // Read address width; kept at least one bit so a single-word bank still has a port.
    function automatic int calc_ra_w(input int data_w, input int depth, input int rd_w);
        int w;
        w = clog2(calc_rd_depth(data_w, depth, rd_w));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tmem_bank.sv
// rtl/tmem_bank.sv - one DEPTH x DATA_W bank with single-entry write and K-entry packed read
module tmem_bank
    import tmem_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  RD_W   = DEF_RD_W,
    localparam int K      = calc_k(DATA_W, RD_W),
    localparam int WA_W   = calc_wa_w(DEPTH),
    localparam int RA_W   = calc_ra_w(DATA_W, DEPTH, RD_W)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [WA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr,
    output logic [RD_W-1:0]   rdata
);

    // Contents are deliberately not reset: every fill rewrites all entries.
    logic [DATA_W-1:0] mem [DEPTH];

    // Single-entry write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Packed read: entry raddr*K+j lands in lane j, so the lowest entry sits in the LSBs.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < K; j++) begin
            rdata[j*DATA_W +: DATA_W] = mem[WA_W'(int'(raddr) * K + j)];
        end
    end

endmodule

// File: rtl/tmem_pp.sv
// rtl/tmem_pp.sv - double-buffered TanH to affine2 activation buffer with commit/release handshakes
module tmem_pp
    import tmem_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  RD_W   = DEF_RD_W,
    localparam int WA_W   = calc_wa_w(DEPTH),
    localparam int RA_W   = calc_ra_w(DATA_W, DEPTH, RD_W)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [WA_W-1:0]   wr_addr,
    input  logic              wr,
    input  logic              wr_done,
    output logic              wr_ready,
    output logic [RD_W-1:0]   data_out,
    input  logic [RA_W-1:0]   rd_addr,
    input  logic              rd,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic              err
);

    logic            wbank;
    logic            rbank;
    logic [1:0]      full;
    logic [1:0]      full_next;

    logic            wr_acc;
    logic            commit_acc;
    logic            rd_acc;
    logic            rel_acc;
    logic            reject;

    logic [RD_W-1:0] rdata0;
    logic [RD_W-1:0] rdata1;

    // Handshake flags depend on state registers only, never on inputs.
    assign wr_ready = !full[wbank];
    assign rd_ready = full[rbank];

    assign wr_acc     = wr && wr_ready;
    assign commit_acc = wr_done && wr_ready;
    assign rd_acc     = rd && rd_ready;
    assign rel_acc    = rd_done && rd_ready;
    assign reject     = ((wr || wr_done) && !wr_ready) || ((rd || rd_done) && !rd_ready);

    tmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_W   (RD_W)
    ) u_bank0 (
        .clock  (clock),
        .we     (wr_acc && (wbank == 1'b0)),
        .waddr  (wr_addr),
        .wdata  (data_in),
        .raddr  (rd_addr),
        .rdata  (rdata0)
    );

    tmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_W   (RD_W)
    ) u_bank1 (
        .clock  (clock),
        .we     (wr_acc && (wbank == 1'b1)),
        .waddr  (wr_addr),
        .wdata  (data_in),
        .raddr  (rd_addr),
        .rdata  (rdata1)
    );

    // Commit and release can only hit different banks (one needs the bank empty, the other full).
    always_comb begin
        full_next = full;
        if (commit_acc) begin
            full_next[wbank] = 1'b1;
        end
        if (rel_acc) begin
            full_next[rbank] = 1'b0;
        end
    end

    // Bank pointers, committed flags and sticky protocol error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
            err   <= 1'b0;
        end else begin
            if (commit_acc) begin
                wbank <= ~wbank;
            end
            if (rel_acc) begin
                rbank <= ~rbank;
            end
            full <= full_next;
            err  <= err | reject;
        end
    end

    // Registered read port; a release in the same cycle still reads the bank being released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= rbank ? rdata1 : rdata0;
            end
        end
    end

endmodule

// File: tb/tb_tmem_pp.sv
// tb/tb_tmem_pp.sv - directed scoreboard bench for tmem_pp at default and 8x64/256 geometries
module tb_tmem_pp;

    logic         clock;
    logic         reset_n;

    logic [3:0]   data_in_a;
    logic [6:0]   wr_addr_a;
    logic         wr_a, wr_done_a, wr_ready_a;
    logic [127:0] data_out_a;
    logic [1:0]   rd_addr_a;
    logic         rd_a, rd_valid_a, rd_done_a, rd_ready_a, err_a;

    logic [7:0]   data_in_b;
    logic [5:0]   wr_addr_b;
    logic         wr_b, wr_done_b, wr_ready_b;
    logic [255:0] data_out_b;
    logic [0:0]   rd_addr_b;
    logic         rd_b, rd_valid_b, rd_done_b, rd_ready_b, err_b;

    int checks = 0;
    int errors = 0;

    logic [127:0] q_a [$];
    logic [255:0] q_b [$];
    logic [3:0]   model_a [2][128];
    logic [7:0]   model_b [64];

    tmem_pp dut_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (data_in_a),
        .wr_addr  (wr_addr_a),
        .wr       (wr_a),
        .wr_done  (wr_done_a),
        .wr_ready (wr_ready_a),
        .data_out (data_out_a),
        .rd_addr  (rd_addr_a),
        .rd       (rd_a),
        .rd_valid (rd_valid_a),
        .rd_done  (rd_done_a),
        .rd_ready (rd_ready_a),
        .err      (err_a)
    );

    tmem_pp #(.DATA_W(8), .DEPTH(64), .RD_W(256)) dut_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (data_in_b),
        .wr_addr  (wr_addr_b),
        .wr       (wr_b),
        .wr_done  (wr_done_b),
        .wr_ready (wr_ready_b),
        .data_out (data_out_b),
        .rd_addr  (rd_addr_b),
        .rd       (rd_b),
        .rd_valid (rd_valid_b),
        .rd_done  (rd_done_b),
        .rd_ready (rd_ready_b),
        .err      (err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_a(input int bank, input int addr);
        logic [127:0] r;
        for (int j = 0; j < 32; j++) r[j*4 +: 4] = model_a[bank][addr*32 + j];
        return r;
    endfunction

    function automatic logic [255:0] pack_b(input int addr);
        logic [255:0] r;
        for (int j = 0; j < 32; j++) r[j*8 +: 8] = model_b[addr*32 + j];
        return r;
    endfunction

    // One cycle on dut_a: drive strobes after a falling edge, hold across the rising edge.
    task automatic cyc_a(input logic w, input logic [6:0] wa, input logic [3:0] d, input logic wd,
                         input logic r, input logic [1:0] ra, input logic rdn);
        wr_a = w; wr_addr_a = wa; data_in_a = d; wr_done_a = wd;
        rd_a = r; rd_addr_a = ra; rd_done_a = rdn;
        @(negedge clock);
        wr_a = 1'b0; wr_done_a = 1'b0; rd_a = 1'b0; rd_done_a = 1'b0;
    endtask

    task automatic wr_entry_a(input int bank, input int addr, input logic [3:0] d);
        model_a[bank][addr] = d;
        cyc_a(1'b1, 7'(addr), d, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rd_word_a(input int bank, input int addr, input logic rdn);
        q_a.push_back(pack_a(bank, addr));
        cyc_a(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 2'(addr), rdn);
    endtask

    task automatic cyc_b(input logic w, input logic [5:0] wa, input logic [7:0] d, input logic wd,
                         input logic r, input logic [0:0] ra);
        wr_b = w; wr_addr_b = wa; data_in_b = d; wr_done_b = wd; rd_b = r; rd_addr_b = ra;
        @(negedge clock);
        wr_b = 1'b0; wr_done_b = 1'b0; rd_b = 1'b0;
    endtask

    // Scoreboard monitors: every rd_valid must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (rd_valid_a) begin
            if (q_a.size() == 0) chk("unexpected_valid_a", 256'(rd_valid_a), 256'(1'b0));
            else chk("read_data_a", 256'(data_out_a), 256'(q_a.pop_front()));
        end
        if (rd_valid_b) begin
            if (q_b.size() == 0) chk("unexpected_valid_b", 256'(rd_valid_b), 256'(1'b0));
            else chk("read_data_b", data_out_b, q_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        {wr_a, wr_done_a, rd_a, rd_done_a} = '0;
        wr_addr_a = '0; data_in_a = '0; rd_addr_a = '0;
        {wr_b, wr_done_b, rd_b, rd_done_b} = '0;
        wr_addr_b = '0; data_in_b = '0; rd_addr_b = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state
        chk("rst_wr_ready_a", 256'(wr_ready_a), 256'(1'b1));
        chk("rst_rd_ready_a", 256'(rd_ready_a), 256'(1'b0));
        chk("rst_data_out_a", 256'(data_out_a), 256'd0);
        chk("rst_rd_valid_a", 256'(rd_valid_a), 256'(1'b0));
        chk("rst_err_a", 256'(err_a), 256'(1'b0));
        chk("rst_wr_ready_b", 256'(wr_ready_b), 256'(1'b1));
        chk("rst_rd_ready_b", 256'(rd_ready_b), 256'(1'b0));
        chk("rst_data_out_b", data_out_b, 256'd0);

        // Fill bank0 with i[3:0], commit, read all four words
        for (int i = 0; i < 128; i++) wr_entry_a(0, i, 4'(i));
        cyc_a(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("commit_rd_ready", 256'(rd_ready_a), 256'(1'b1));
        chk("commit_wr_ready", 256'(wr_ready_a), 256'(1'b1));
        chk("pattern_model", 256'(pack_a(0, 0)), 256'(128'hFEDCBA98_76543210_FEDCBA98_76543210));
        for (int a = 0; a < 4; a++) rd_word_a(0, a, 1'b0);
        @(negedge clock);
        chk("fill_err", 256'(err_a), 256'(1'b0));

        // Ping-pong: release bank0, fill/commit bank1 with 5s, read it while filling bank0 with As
        cyc_a(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 128; i++) wr_entry_a(1, i, 4'h5);
        cyc_a(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("pp_rd_ready", 256'(rd_ready_a), 256'(1'b1));
        for (int i = 0; i < 128; i++) begin
            model_a[0][i] = 4'hA;
            q_a.push_back(pack_a(1, i % 4));
            cyc_a(1'b1, 7'(i), 4'hA, 1'b0, 1'b1, 2'(i % 4), 1'b0);
        end
        // Release of bank1 and commit of bank0 in the same cycle
        cyc_a(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b1);
        chk("pp_swap_rd_ready", 256'(rd_ready_a), 256'(1'b1));
        chk("pp_swap_wr_ready", 256'(wr_ready_a), 256'(1'b1));
        for (int a = 0; a < 4; a++) rd_word_a(0, a, 1'b0);

        // Back-pressure: commit bank1 too, then a rejected write
        for (int i = 0; i < 128; i++) wr_entry_a(1, i, 4'(i * 3 + 1));
        cyc_a(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("bp_wr_ready", 256'(wr_ready_a), 256'(1'b0));
        chk("bp_err_before", 256'(err_a), 256'(1'b0));
        cyc_a(1'b1, 7'd3, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("bp_err_after", 256'(err_a), 256'(1'b1));
        rd_word_a(0, 0, 1'b0);
        cyc_a(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("bp_release_wr_ready", 256'(wr_ready_a), 256'(1'b1));
        rd_word_a(1, 0, 1'b0);
        @(negedge clock);

        // Asynchronous reset in the middle of a read
        rd_a = 1'b1; rd_addr_a = 2'd1;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_data_out", 256'(data_out_a), 256'd0);
        chk("mid_rst_rd_valid", 256'(rd_valid_a), 256'(1'b0));
        chk("mid_rst_rd_ready", 256'(rd_ready_a), 256'(1'b0));
        chk("mid_rst_wr_ready", 256'(wr_ready_a), 256'(1'b1));
        chk("mid_rst_err", 256'(err_a), 256'(1'b0));
        rd_a = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Same-cycle write and commit; same-cycle read and release
        for (int i = 0; i < 127; i++) wr_entry_a(0, i, 4'h0);
        model_a[0][127] = 4'h9;
        cyc_a(1'b1, 7'd127, 4'h9, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("sim_commit_rd_ready", 256'(rd_ready_a), 256'(1'b1));
        rd_word_a(0, 3, 1'b0);
        rd_word_a(0, 3, 1'b1);
        chk("sim_release_rd_ready", 256'(rd_ready_a), 256'(1'b0));
        chk("sim_release_wr_ready", 256'(wr_ready_a), 256'(1'b1));
        for (int i = 0; i < 128; i++) wr_entry_a(1, i, 4'(15 - i));
        cyc_a(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("sim_bank1_rd_ready", 256'(rd_ready_a), 256'(1'b1));
        rd_word_a(1, 2, 1'b0);
        cyc_a(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("uf_rd_ready", 256'(rd_ready_a), 256'(1'b0));
        chk("uf_err_before", 256'(err_a), 256'(1'b0));

        // Underflow: read with nothing committed
        cyc_a(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 2'd1, 1'b0);
        chk("uf_rd_valid", 256'(rd_valid_a), 256'(1'b0));
        chk("uf_data_out_hold", 256'(data_out_a), 256'(pack_a(1, 2)));
        chk("uf_err", 256'(err_a), 256'(1'b1));
        @(negedge clock);
        chk("sb_a_drained", 256'(q_a.size()), 256'd0);

        // Parametrised instance: 8-bit x 64 entries, 256-bit words
        for (int i = 0; i < 64; i++) begin
            model_b[i] = 8'(i);
            cyc_b(1'b1, 6'(i), 8'(i), 1'b0, 1'b0, 1'b0);
        end
        cyc_b(1'b0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("b_rd_ready", 256'(rd_ready_b), 256'(1'b1));
        chk("b_pattern_model", pack_b(1),
            256'h3F3E3D3C_3B3A3938_37363534_33323130_2F2E2D2C_2B2A2928_27262524_23222120);
        for (int a = 0; a < 2; a++) begin
            q_b.push_back(pack_b(a));
            cyc_b(1'b0, 6'd0, 8'd0, 1'b0, 1'b1, 1'(a));
        end
        @(negedge clock);
        chk("b_err", 256'(err_b), 256'(1'b0));
        chk("sb_b_drained", 256'(q_b.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmem_pp.md
# tmem_pp

Parametrised, double-buffered successor of the layer-1 TanH → affine2 buffer.
- The producer (TanH stage) writes one DATA_W-bit activation per cycle into the fill bank.
- The consumer (affine2) reads RD_W-bit packed words from the other, committed bank.
- Two banks with explicit commit/release handshakes let layer 1 of sample n+1 overlap affine2 of sample n.
- Defaults reproduce the original geometry: 128 × 4-bit in, 4 × 128-bit out.

## Interface
Parameters:
- DATA_W, 4, bits per written entry
- DEPTH, 128, entries per bank; power of two
- RD_W, 128, read word width; multiple of DATA_W; DEPTH*DATA_W divisible by RD_W
- Derived, not overridable:
  - K = RD_W/DATA_W
  - RD_DEPTH = DEPTH/K
  - WA_W = clog2(DEPTH)
  - RA_W = max(1, clog2(RD_DEPTH))

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  write data
- wr_addr  in  WA_W  write entry address
- wr  in  1  write strobe
- wr_done  in  1  commit current fill bank
- wr_ready  out  1  fill bank free (writes/commit accepted)
- data_out  out  RD_W  registered read data
- rd_addr  in  RA_W  read word address
- rd  in  1  read strobe
- rd_valid  out  1  data_out updated this cycle
- rd_done  in  1  release current read bank
- rd_ready  out  1  a committed bank is readable
- err  out  1  sticky protocol error

## Operation
- State registers:
  - wbank: fill bank pointer
  - rbank: read bank pointer
  - full[1:0]: per-bank committed flags
- wr_ready = !full[wbank]; rd_ready = full[rbank]. Both are combinational from registers only.
- Write: wr && wr_ready → bank[wbank][wr_addr] <= data_in.
- Commit: wr_done && wr_ready → full[wbank] <= 1, wbank toggles.
- Read: rd && rd_ready → data_out <= {bank[rbank][rd_addr*K+K-1], …, bank[rbank][rd_addr*K]}. The lowest entry lands in bits [DATA_W-1:0]. rd_valid pulses the following cycle.
- Release: rd_done && rd_ready → full[rbank] <= 0, rbank toggles.
- Same-cycle wr and wr_done: the write lands in the bank being committed.
- Same-cycle rd and rd_done: the read samples the bank being released.
- Simultaneous commit and release act independently, including when both target different banks in the same cycle.
- Rejected operations set err and leave all state unchanged:
  - wr or wr_done with wr_ready=0 (both banks full)
  - rd or rd_done with rd_ready=0 (no committed bank)
- RAM contents are not cleared on commit, release or reset. The producer writes all DEPTH entries per fill; unwritten entries return stale data.
- data_out holds its last value when no read is accepted.
- Reset (asynchronous assert, synchronous release): wbank=0, rbank=0, full=00, data_out=0, rd_valid=0, err=0.
- Reset mid-fill or mid-read discards both banks' status.
- err clears only on reset.

## Timing
- Write-to-RAM: 1 cycle. A read accepted in the cycle after the last write to that bank observes the written value.
- Read latency: 1 cycle, rd at edge t → data_out/rd_valid valid after edge t+1. Full throughput: one read per cycle.
- Commit → rd_ready: asserted the cycle after the wr_done edge, if rbank points at that bank.
- Release → wr_ready: a producer stalled on both-full sees wr_ready the cycle after the rd_done edge.
- No combinational path from any input to any output.

## Structure
- Package tmem_pkg:
  - default values of DATA_W, DEPTH, RD_W
  - a clog2 helper
  - the derived-width formulas, so affine2 and the TanH stage size their address buses identically
- Sub-module tmem_bank:
  - one bank, DEPTH × DATA_W
  - single-entry write, K-entry wide registered-free read mux
  - instantiated twice
- Control: wbank, rbank, full, err and the output register, in tmem_pp.

## Test plan
- Fill/read, defaults: write entry i = i[3:0] for i=0..127, then wr_done.
  - rd_ready rises next cycle.
  - rd_addr=0 → data_out=128'hFEDCBA98_76543210_FEDCBA98_76543210 one cycle later, rd_valid=1.
  - rd_addr 1..3 return the same value.
- Ping-pong overlap: commit bank0 (all 4'h5), start filling bank1 (all 4'hA) while reading bank0.
  - Reads return all-5 nibbles.
  - After rd_done then bank1 commit, reads return all-A.
- Back-pressure: commit both banks.
  - wr_ready=0.
  - A wr at addr 3 is ignored and err=1.
  - After one rd_done, wr_ready=1 the next cycle.
- Underflow: rd with rd_ready=0 → rd_valid stays 0, data_out unchanged, err=1.
- Simultaneous events:
  - wr+wr_done in the same cycle: the entry is present in the committed bank.
  - rd+rd_done in the same cycle: returns old-bank data, and rbank toggles.
- Async reset mid-read, and a parametrised run with DATA_W=8, DEPTH=64, RD_W=256:
  - After reset: full=00, rd_ready=0, wr_ready=1, data_out=0.
  - Parametrised run, K=32, RD_DEPTH=2: packing order is verified as in the first scenario.
